// File: rtl/tmul_pkg.sv
// Shared sizing constants and FSM state type for the tile-multiplier
// accumulate-and-drain block.
package tmul_pkg;

    localparam int LANES = 8;
    localparam int C_W   = 64;
    localparam int ACC_W = 72;

    typedef enum logic {
        ACCUM = 1'b0,
        DRAIN = 1'b1
    } state_t;

endpackage

// File: rtl/tmul_acc_lane.sv
// One result lane: adds a zero-extended multiplier result into its accumulator,
// restarting from zero on the first tile of a group, and reports the carry-out.
module tmul_acc_lane #(
    parameter int C_W   = tmul_pkg::C_W,
    parameter int ACC_W = tmul_pkg::ACC_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             first,
    input  logic [C_W-1:0]   in_lane,
    output logic [ACC_W-1:0] acc,
    output logic             carry
);

    logic [ACC_W-1:0] base;
    logic [ACC_W:0]   sum;

    // The extra top bit of the sum is the modulo-2^ACC_W carry-out.
    always_comb begin
        base  = first ? '0 : acc;
        sum   = {1'b0, base} + (ACC_W + 1)'(in_lane);
        carry = sum[ACC_W];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc <= '0;
        end else if (load) begin
            acc <= sum[ACC_W-1:0];
        end
    end

endmodule

// File: rtl/tmul_acc_drain.sv
// Accumulates tile-multiplier results per lane across a group of tiles, then
// drains the lane sums one per handshake before accepting the next group.
module tmul_acc_drain
    import tmul_pkg::*;
#(
    parameter int LANES = tmul_pkg::LANES,
    parameter int C_W   = tmul_pkg::C_W,
    parameter int ACC_W = tmul_pkg::ACC_W
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    input  logic [LANES*C_W-1:0]     in_c,
    input  logic                     in_last,
    output logic                     in_ready,
    output logic                     out_valid,
    output logic [ACC_W-1:0]         out_data,
    output logic [$clog2(LANES)-1:0] out_idx,
    output logic                     out_last,
    input  logic                     out_ready,
    output logic                     ovf
);

    localparam int IDX_W = $clog2(LANES);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(LANES - 1);

    state_t           state;
    logic [IDX_W-1:0] idx;
    logic             first;
    logic             accept;
    logic [ACC_W-1:0] lane_acc [LANES];
    logic [LANES-1:0] lane_carry;

    assign accept = in_valid && in_ready;

    for (genvar g = 0; g < LANES; g++) begin : g_lane
        tmul_acc_lane #(
            .C_W   (C_W),
            .ACC_W (ACC_W)
        ) u_lane (
            .clk     (clk),
            .rst     (rst),
            .load    (accept),
            .first   (first),
            .in_lane (in_c[g*C_W +: C_W]),
            .acc     (lane_acc[g]),
            .carry   (lane_carry[g])
        );
    end

    // Handshake flags are registered alongside the state so they never depend
    // combinationally on the in_* ports.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ACCUM;
            idx       <= '0;
            first     <= 1'b1;
            ovf       <= 1'b0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
        end else begin
            case (state)
                ACCUM: begin
                    if (in_valid) begin
                        first <= 1'b0;
                        ovf   <= (first ? 1'b0 : ovf) | (|lane_carry);
                        if (in_last) begin
                            state     <= DRAIN;
                            idx       <= '0;
                            in_ready  <= 1'b0;
                            out_valid <= 1'b1;
                            out_last  <= (LAST_IDX == '0);
                        end
                    end
                end
                DRAIN: begin
                    if (out_ready) begin
                        if (idx == LAST_IDX) begin
                            state     <= ACCUM;
                            idx       <= '0;
                            first     <= 1'b1;
                            in_ready  <= 1'b1;
                            out_valid <= 1'b0;
                            out_last  <= 1'b0;
                        end else begin
                            idx      <= idx + IDX_W'(1);
                            out_last <= ((idx + IDX_W'(1)) == LAST_IDX);
                        end
                    end
                end
                default: begin
                    state <= ACCUM;
                end
            endcase
        end
    end

    assign out_data = lane_acc[idx];
    assign out_idx  = idx;

endmodule

// File: tb/tb_tmul_acc_drain.sv
// Self-checking bench: directed group scenarios plus randomized traffic, all
// compared every cycle against a queue-based model of the lane sums.
module tb_tmul_acc_drain;

    localparam int LANES = 8;
    localparam int C_W   = 64;
    localparam int ACC_W = 72;
    localparam int IDX_W = $clog2(LANES);

    typedef logic [ACC_W-1:0] acc_t;

    logic                 clk = 1'b0;
    logic                 rst = 1'b1;
    logic                 in_valid = 1'b0;
    logic [LANES*C_W-1:0] in_c = '0;
    logic                 in_last = 1'b0;
    logic                 in_ready;
    logic                 out_valid;
    logic [ACC_W-1:0]     out_data;
    logic [IDX_W-1:0]     out_idx;
    logic                 out_last;
    logic                 out_ready = 1'b0;
    logic                 ovf;

    int checks = 0;
    int errors = 0;

    logic [C_W-1:0] tile [LANES];
    acc_t           exp_vals [LANES];

    tmul_acc_drain #(
        .LANES (LANES),
        .C_W   (C_W),
        .ACC_W (ACC_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_c      (in_c),
        .in_last   (in_last),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_idx   (out_idx),
        .out_last  (out_last),
        .out_ready (out_ready),
        .ovf       (ovf)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input acc_t actual, input acc_t expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Reference model: per-lane sums in plain arithmetic, and a queue of lane
    // results still owed downstream. Input is accepted only when nothing is owed.
    acc_t m_sum [LANES];
    bit   m_first = 1'b1;
    bit   m_ovf = 1'b0;
    bit   model_live = 1'b0;
    acc_t q_data [$];
    int   q_idx [$];

    always @(posedge clk) begin
        if (rst) begin
            q_data.delete();
            q_idx.delete();
            for (int i = 0; i < LANES; i++) m_sum[i] = '0;
            m_first = 1'b1;
            m_ovf = 1'b0;
            model_live = 1'b1;
        end else if (q_data.size() == 0) begin
            if (in_valid) begin
                logic [ACC_W:0] wide;
                if (m_first) m_ovf = 1'b0;
                for (int i = 0; i < LANES; i++) begin
                    wide = (m_first ? '0 : {1'b0, m_sum[i]}) + (ACC_W + 1)'(in_c[i*C_W +: C_W]);
                    if (wide > {1'b0, {ACC_W{1'b1}}}) m_ovf = 1'b1;
                    m_sum[i] = wide[ACC_W-1:0];
                end
                m_first = 1'b0;
                if (in_last) begin
                    for (int i = 0; i < LANES; i++) begin
                        q_data.push_back(m_sum[i]);
                        q_idx.push_back(i);
                    end
                end
            end
        end else if (out_ready) begin
            void'(q_data.pop_front());
            void'(q_idx.pop_front());
            if (q_data.size() == 0) m_first = 1'b1;
        end
    end

    always @(negedge clk) begin
        if (model_live) begin
            checkOutput("model in_ready", acc_t'(in_ready), acc_t'(q_data.size() == 0));
            checkOutput("model out_valid", acc_t'(out_valid), acc_t'(q_data.size() != 0));
            checkOutput("model ovf", acc_t'(ovf), acc_t'(m_ovf));
            if (q_data.size() != 0) begin
                checkOutput("model out_data", out_data, q_data[0]);
                checkOutput("model out_idx", acc_t'(out_idx), acc_t'(q_idx[0]));
                checkOutput("model out_last", acc_t'(out_last), acc_t'(q_idx[0] == LANES - 1));
            end
        end
    end

    task automatic applyStimulus(input bit v, input bit last);
        in_valid = v;
        in_last  = last;
        for (int i = 0; i < LANES; i++) in_c[i*C_W +: C_W] = tile[i];
        @(posedge clk);
        #1;
    endtask

    task automatic send_group(input int n_tiles);
        checkOutput("in_ready before group", acc_t'(in_ready), acc_t'(1));
        for (int t = 0; t < n_tiles; t++) applyStimulus(1'b1, t == n_tiles - 1);
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    // Drains one group against exp_vals; optionally stalls at a lane, or keeps
    // junk tiles offered on the input the whole time.
    task automatic drain_expect(input bit exp_ovf, input int stall_idx, input int stall_len, input bit junk);
        out_ready = 1'b1;
        if (junk) begin
            in_valid = 1'b1;
            in_last  = 1'b1;
            for (int i = 0; i < LANES; i++) in_c[i*C_W +: C_W] = C_W'(999);
        end
        for (int k = 0; k < LANES; k++) begin
            if (k == stall_idx) begin
                out_ready = 1'b0;
                for (int s = 0; s < stall_len; s++) begin
                    checkOutput("stall out_data", out_data, exp_vals[k]);
                    checkOutput("stall out_idx", acc_t'(out_idx), acc_t'(k));
                    checkOutput("stall out_valid", acc_t'(out_valid), acc_t'(1));
                    @(posedge clk);
                    #1;
                end
                out_ready = 1'b1;
            end
            checkOutput("drain out_valid", acc_t'(out_valid), acc_t'(1));
            checkOutput("drain in_ready", acc_t'(in_ready), acc_t'(0));
            checkOutput("drain out_data", out_data, exp_vals[k]);
            checkOutput("drain out_idx", acc_t'(out_idx), acc_t'(k));
            checkOutput("drain out_last", acc_t'(out_last), acc_t'(k == LANES - 1));
            checkOutput("drain ovf", acc_t'(ovf), acc_t'(exp_ovf));
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        checkOutput("in_ready after drain", acc_t'(in_ready), acc_t'(1));
        checkOutput("out_valid after drain", acc_t'(out_valid), acc_t'(0));
    endtask

    initial begin
        for (int i = 0; i < LANES; i++) tile[i] = '0;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset in_ready", acc_t'(in_ready), acc_t'(1));
        checkOutput("reset out_valid", acc_t'(out_valid), acc_t'(0));
        checkOutput("reset out_last", acc_t'(out_last), acc_t'(0));
        checkOutput("reset out_data", out_data, acc_t'(0));
        checkOutput("reset out_idx", acc_t'(out_idx), acc_t'(0));
        checkOutput("reset ovf", acc_t'(ovf), acc_t'(0));
        rst = 1'b0;

        $display("[TB] single tile, lanes 1..8");
        for (int i = 0; i < LANES; i++) begin
            tile[i] = C_W'(i + 1);
            exp_vals[i] = acc_t'(i + 1);
        end
        send_group(1);
        drain_expect(1'b0, -1, 0, 1'b0);

        $display("[TB] three tiles of 100, then one tile of 5");
        for (int i = 0; i < LANES; i++) begin
            tile[i] = C_W'(100);
            exp_vals[i] = acc_t'(300);
        end
        send_group(3);
        drain_expect(1'b0, -1, 0, 1'b0);
        for (int i = 0; i < LANES; i++) begin
            tile[i] = C_W'(5);
            exp_vals[i] = acc_t'(5);
        end
        send_group(1);
        drain_expect(1'b0, -1, 0, 1'b0);

        $display("[TB] stall five cycles at lane 3");
        for (int i = 0; i < LANES; i++) begin
            tile[i] = C_W'(i * 11 + 3);
            exp_vals[i] = acc_t'(2 * (i * 11 + 3));
        end
        send_group(2);
        drain_expect(1'b0, 3, 5, 1'b0);

        $display("[TB] lane 0 saturation, 256 then 257 tiles");
        for (int i = 0; i < LANES; i++) begin
            tile[i] = '0;
            exp_vals[i] = '0;
        end
        tile[0] = {C_W{1'b1}};
        exp_vals[0] = 72'hFF_FFFF_FFFF_FFFF_FF00;
        send_group(256);
        drain_expect(1'b0, -1, 0, 1'b0);
        exp_vals[0] = 72'h00_FFFF_FFFF_FFFF_FEFF;
        send_group(257);
        drain_expect(1'b1, -1, 0, 1'b0);

        $display("[TB] reset mid-drain at lane 4");
        for (int i = 0; i < LANES; i++) begin
            tile[i] = C_W'(20 + i);
            exp_vals[i] = acc_t'(20 + i);
        end
        send_group(1);
        out_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            checkOutput("partial out_data", out_data, exp_vals[k]);
            @(posedge clk);
            #1;
        end
        checkOutput("partial out_idx", acc_t'(out_idx), acc_t'(4));
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        checkOutput("post-reset out_valid", acc_t'(out_valid), acc_t'(0));
        checkOutput("post-reset in_ready", acc_t'(in_ready), acc_t'(1));
        checkOutput("post-reset out_idx", acc_t'(out_idx), acc_t'(0));
        checkOutput("post-reset out_data", out_data, acc_t'(0));
        for (int i = 0; i < LANES; i++) begin
            tile[i] = C_W'(7);
            exp_vals[i] = acc_t'(7);
        end
        send_group(1);
        drain_expect(1'b0, -1, 0, 1'b0);

        $display("[TB] input offered during drain is ignored");
        for (int i = 0; i < LANES; i++) begin
            tile[i] = C_W'(40 + i);
            exp_vals[i] = acc_t'(40 + i);
        end
        send_group(1);
        drain_expect(1'b0, -1, 0, 1'b1);
        for (int i = 0; i < LANES; i++) begin
            tile[i] = C_W'(1);
            exp_vals[i] = acc_t'(1);
        end
        send_group(1);
        drain_expect(1'b0, -1, 0, 1'b0);

        $display("[TB] randomized traffic");
        for (int c = 0; c < 4000; c++) begin
            for (int i = 0; i < LANES; i++) begin
                tile[i] = ($urandom_range(0, 3) == 0) ? {$urandom, $urandom}
                                                      : C_W'($urandom_range(0, 1000));
            end
            out_ready = ($urandom_range(0, 3) != 0);
            rst = ($urandom_range(0, 299) == 0);
            applyStimulus($urandom_range(0, 1) == 1, $urandom_range(0, 4) == 0);
        end
        rst = 1'b0;
        in_valid = 1'b0;
        in_last = 1'b0;
        out_ready = 1'b1;
        repeat (2 * LANES) @(posedge clk);
        #1;
        checkOutput("final in_ready", acc_t'(in_ready), acc_t'(1));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
